// File: rtl/err_compute_gen.sv
// Serial IR steering-error engine. It computes sum_i (R_i - L_i) << i one term per clock,
// then saturates the result, optionally IIR-filters it, and flags line loss on low total intensity.
module err_compute_gen #(
  parameter int N_PAIRS  = 4,
  parameter int IR_W     = 12,
  parameter int ERR_W    = 16,
  parameter int AVG_LOG2 = 0,
  parameter int LOST_THR = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      IR_vld,
  input  logic [N_PAIRS*IR_W-1:0]   IR_R,
  input  logic [N_PAIRS*IR_W-1:0]   IR_L,
  output logic signed [ERR_W-1:0]   error,
  output logic                      err_vld,
  output logic                      line_lost,
  output logic                      busy
);

  localparam int N_TERMS = 2 * N_PAIRS;
  localparam int K_W     = $clog2(N_TERMS);
  localparam int ACC_W   = IR_W + N_PAIRS + 1;
  localparam int SUM_W   = IR_W + $clog2(N_TERMS) + 1;
  localparam int WIDE_W  = ((ACC_W > ERR_W) ? ACC_W : ERR_W) + 1;

  localparam logic [K_W-1:0] K_LAST = K_W'(N_TERMS - 1);
  localparam logic signed [WIDE_W-1:0] SAT_HI = {{(WIDE_W-ERR_W+1){1'b0}}, {(ERR_W-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] SAT_LO = {{(WIDE_W-ERR_W+1){1'b1}}, {(ERR_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e                    state_q, state_d;
  logic [K_W-1:0]            k_q, k_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [SUM_W-1:0]          sum_q, sum_d;
  logic [N_PAIRS*IR_W-1:0]   r_q, r_d, l_q, l_d;
  logic signed [ERR_W-1:0]   error_q, error_d;
  logic                      vld_q, vld_d, lost_q, lost_d, busy_q, busy_d;

  int                        pair_idx;
  logic [IR_W-1:0]           reading;
  logic signed [ACC_W-1:0]   term;
  logic signed [WIDE_W-1:0]  acc_wide;
  logic signed [ERR_W-1:0]   raw;
  logic signed [ERR_W:0]     diff, step, filt;

  // Even k selects R_i, odd k selects L_i, both weighted by 2^i.
  always_comb begin
    pair_idx = int'(k_q >> 1);
    reading  = k_q[0] ? l_q[IR_W*pair_idx +: IR_W] : r_q[IR_W*pair_idx +: IR_W];
    term     = $signed({{(ACC_W-IR_W){1'b0}}, reading}) <<< pair_idx;
  end

  always_comb begin
    acc_wide = WIDE_W'(acc_q);
    if (acc_wide > SAT_HI)      raw = SAT_HI[ERR_W-1:0];
    else if (acc_wide < SAT_LO) raw = SAT_LO[ERR_W-1:0];
    else                        raw = acc_wide[ERR_W-1:0];
    // One guard bit keeps raw - error exact; the filtered result stays between old and raw.
    diff = (ERR_W+1)'(raw) - (ERR_W+1)'(error_q);
    step = diff >>> AVG_LOG2;
    filt = (ERR_W+1)'(error_q) + step;
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    r_d     = r_q;
    l_d     = l_q;
    error_d = error_q;
    lost_d  = lost_q;
    busy_d  = busy_q;
    vld_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (IR_vld) begin
          r_d     = IR_R;
          l_d     = IR_L;
          acc_d   = '0;
          sum_d   = '0;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = k_q[0] ? acc_q - term : acc_q + term;
        sum_d = sum_q + SUM_W'(reading);
        k_d   = k_q + 1'b1;
        if (k_q == K_LAST) state_d = DONE;
      end
      DONE: begin
        error_d = (AVG_LOG2 == 0) ? raw : filt[ERR_W-1:0];
        lost_d  = int'(sum_q) < LOST_THR;
        vld_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      // NOTE: the snapshot is reset too, so a reset mid-frame never leaves stale data to be read.
      r_q     <= '0;
      l_q     <= '0;
      error_q <= '0;
      vld_q   <= 1'b0;
      lost_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      r_q     <= r_d;
      l_q     <= l_d;
      error_q <= error_d;
      vld_q   <= vld_d;
      lost_q  <= lost_d;
      busy_q  <= busy_d;
    end
  end

  assign error     = error_q;
  assign err_vld   = vld_q;
  assign line_lost = lost_q;
  assign busy      = busy_q;

endmodule
